pipe_hazard_ctrl: RTL

PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

---
 rtl/pipe_hazard_if.sv | 43 ++++
 rtl/pipe_hazard_ctrl.sv | 144 ++++++++++++++
 2 files changed

// File: rtl/pipe_hazard_if.sv
// Hazard-controller bundle: pipeline stage status in, freeze/flush controls and statistics out.
interface pipe_hazard_if #(
    parameter int unsigned CNT_W = 16
);
    logic             forward_en;
    logic [3:0]       id_src1;
    logic [3:0]       id_src2;
    logic             id_src1_v;
    logic             id_src2_v;
    logic [3:0]       exe_dest;
    logic             exe_wb_en;
    logic             exe_mem_r_en;
    logic [3:0]       mem_dest;
    logic             mem_wb_en;
    logic             branch_taken;
    logic             mem_access;
    logic             mem_ready;
    logic             err_clr;
    logic             freeze_if;
    logic             freeze_id;
    logic             freeze_exe;
    logic             flush_if;
    logic             bubble_id;
    logic             timeout_err;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;

    modport master (
        output forward_en, id_src1, id_src2, id_src1_v, id_src2_v,
               exe_dest, exe_wb_en, exe_mem_r_en, mem_dest, mem_wb_en,
               branch_taken, mem_access, mem_ready, err_clr,
        input  freeze_if, freeze_id, freeze_exe, flush_if, bubble_id,
               timeout_err, stall_cnt, flush_cnt
    );

    modport slave (
        input  forward_en, id_src1, id_src2, id_src1_v, id_src2_v,
               exe_dest, exe_wb_en, exe_mem_r_en, mem_dest, mem_wb_en,
               branch_taken, mem_access, mem_ready, err_clr,
        output freeze_if, freeze_id, freeze_exe, flush_if, bubble_id,
               timeout_err, stall_cnt, flush_cnt
    );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: data-hazard stalls, branch flushes, memory-wait freezes
// with a timeout fault, and saturating stall/flush statistics.
module pipe_hazard_ctrl #(
    parameter int unsigned TIMEOUT = 255,
    parameter int unsigned CNT_W   = 16
) (
    input  logic         clk,
    input  logic         rst,
    pipe_hazard_if.slave hz
);
    localparam int unsigned TO_W   = $clog2(TIMEOUT + 1);
    localparam int unsigned WCNT_W = (TO_W > 8) ? TO_W : 8;
    localparam logic [WCNT_W-1:0] WCNT_LAST = WCNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        FAULT    = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [WCNT_W-1:0] wcnt_q, wcnt_d;
    logic              err_q, err_d;
    logic [CNT_W-1:0]  stall_q, flush_q;

    logic mem_stall;
    logic hazard;
    logic s1_exe, s2_exe, s1_mem, s2_mem;
    logic fz_if, fz_id, fz_exe, fl_if, bub_id;

    assign mem_stall = hz.mem_access & ~hz.mem_ready;
    assign s1_exe    = (hz.id_src1 == hz.exe_dest);
    assign s2_exe    = (hz.id_src2 == hz.exe_dest);
    assign s1_mem    = (hz.id_src1 == hz.mem_dest);
    assign s2_mem    = (hz.id_src2 == hz.mem_dest);

    // With forwarding only a load in EXE can't be bypassed; without it any pending write stalls.
    always_comb begin
        hazard = 1'b0;
        if (hz.forward_en) begin
            hazard = hz.exe_wb_en & hz.exe_mem_r_en &
                     ((hz.id_src1_v & s1_exe) | (hz.id_src2_v & s2_exe));
        end else begin
            hazard = (hz.id_src1_v & ((s1_exe & hz.exe_wb_en) | (s1_mem & hz.mem_wb_en))) |
                     (hz.id_src2_v & ((s2_exe & hz.exe_wb_en) | (s2_mem & hz.mem_wb_en)));
        end
    end

    // Prioritised pipeline controls: memory wait/fault > branch flush > data hazard.
    always_comb begin
        fz_if  = 1'b0;
        fz_id  = 1'b0;
        fz_exe = 1'b0;
        fl_if  = 1'b0;
        bub_id = 1'b0;
        if (!rst) begin
            if (mem_stall || (state_q == FAULT)) begin
                fz_if  = 1'b1;
                fz_id  = 1'b1;
                fz_exe = 1'b1;
            end else if (hz.branch_taken) begin
                fl_if  = 1'b1;
                bub_id = 1'b1;
            end else if (hazard) begin
                fz_if  = 1'b1;
                bub_id = 1'b1;
            end
        end
    end

    // Next state: track consecutive memory-wait cycles and trap into FAULT on timeout.
    always_comb begin
        state_d = state_q;
        wcnt_d  = wcnt_q;
        err_d   = err_q;
        case (state_q)
            RUN: begin
                if (mem_stall) begin
                    state_d = MEM_WAIT;
                    wcnt_d  = WCNT_W'(1);
                end
            end
            MEM_WAIT: begin
                if (hz.mem_ready) begin
                    state_d = RUN;
                    wcnt_d  = '0;
                end else if (mem_stall && (wcnt_q == WCNT_LAST)) begin
                    state_d = FAULT;
                    err_d   = 1'b1;
                end else if (wcnt_q != WCNT_LAST) begin
                    wcnt_d = wcnt_q + WCNT_W'(1);
                end
            end
            FAULT: begin
                if (hz.err_clr) begin
                    state_d = RUN;
                    wcnt_d  = '0;
                    err_d   = 1'b0;
                end
            end
            default: begin
                state_d = RUN;
                wcnt_d  = '0;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= RUN;
            wcnt_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            wcnt_q  <= wcnt_d;
            err_q   <= err_d;
        end
    end

    // Saturating statistics of stalled and flushed cycles.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_q <= '0;
            flush_q <= '0;
        end else begin
            if (fz_if && (stall_q != '1)) begin
                stall_q <= stall_q + CNT_W'(1);
            end
            if (fl_if && (flush_q != '1)) begin
                flush_q <= flush_q + CNT_W'(1);
            end
        end
    end

    assign hz.freeze_if   = fz_if;
    assign hz.freeze_id   = fz_id;
    assign hz.freeze_exe  = fz_exe;
    assign hz.flush_if    = fl_if;
    assign hz.bubble_id   = bub_id;
    assign hz.timeout_err = err_q;
    assign hz.stall_cnt   = stall_q;
    assign hz.flush_cnt   = flush_q;
endmodule
